// File: rtl/mux_scan_controller.sv
// Scans a 4-bit word through an external 4:1 mux, one select every DWELL cycles, and rebuilds it from Y.
// done pulses 4*DWELL cycles after start is accepted; start is only accepted when idle and is never queued.
module mux_scan_controller #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] data_in,
  output logic [3:0] I,
  output logic [1:0] S,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] cap,
  output logic       mismatch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

  state_t     state_q, state_d;
  logic [3:0] i_q, i_d;
  logic [1:0] s_q, s_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cap_q, cap_d;
  logic       mismatch_q, mismatch_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] cap_smp;

  // Capture word as it will look once the current select's bit is stored.
  always_comb begin
    cap_smp      = cap_q;
    cap_smp[s_q] = y_in;
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    s_d        = s_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    mismatch_d = mismatch_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          i_d        = data_in;
          s_d        = 2'd0;
          cnt_d      = 4'd0;
          cap_d      = 4'd0;
          mismatch_d = 1'b0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          cap_d = cap_smp;
          cnt_d = 4'd0;
          if (s_q == 2'd3) begin
            state_d    = DONE;
            mismatch_d = (cap_smp != i_q);
          end else begin
            s_d = s_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= 4'd0;
      s_q        <= 2'd0;
      cnt_q      <= 4'd0;
      cap_q      <= 4'd0;
      mismatch_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      mismatch_q <= mismatch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign I        = i_q;
  assign S        = s_q;
  assign cap      = cap_q;
  assign mismatch = mismatch_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mux_scan_controller.sv
// Directed bench for mux_scan_controller: DWELL=2 instance plus a DWELL=1 instance, ideal mux Y=I[S].
module tb_mux_scan_controller;

  logic       clk;
  logic       rst;
  logic       start0, start1;
  logic [3:0] data_in0, data_in1;
  logic [3:0] i0, i1;
  logic [1:0] s0, s1;
  logic       y_in0, y_in1;
  logic       busy0, busy1;
  logic       done0, done1;
  logic [3:0] cap0, cap1;
  logic       mismatch0, mismatch1;
  logic       tie_zero;

  int checks;
  int errors;

  assign y_in0 = tie_zero ? 1'b0 : i0[s0];
  assign y_in1 = i1[s1];

  mux_scan_controller #(.DWELL(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .data_in(data_in0),
    .I(i0), .S(s0), .y_in(y_in0), .busy(busy0), .done(done0),
    .cap(cap0), .mismatch(mismatch0)
  );

  mux_scan_controller #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data_in1),
    .I(i1), .S(s1), .y_in(y_in1), .busy(busy1), .done(done1),
    .cap(cap1), .mismatch(mismatch1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    data_in0 = 4'b0; data_in1 = 4'b0; tie_zero = 1'b0;
    #2;
    checks++; if (i0 !== 4'b0)     begin errors++; $display("FAIL reset_I got %b want 0000", i0); end
    checks++; if (s0 !== 2'b0)     begin errors++; $display("FAIL reset_S got %b want 00", s0); end
    checks++; if (busy0 !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
    checks++; if (done0 !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done0); end
    checks++; if (cap0 !== 4'b0)   begin errors++; $display("FAIL reset_cap got %b want 0000", cap0); end
    checks++; if (mismatch0 !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %b want 0", mismatch0); end
    checks++; if (busy1 !== 1'b0)  begin errors++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_scan();
    logic [1:0] exp_s;
    start0 = 1'b1; data_in0 = 4'b1001;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_s = 2'(k / 2);
      checks++; if (s0 !== exp_s) begin errors++; $display("FAIL basic_S edge%0d got %b want %b", k, s0, exp_s); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL basic_done_early edge%0d got %b want 0", k, done0); end
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy edge%0d got %b want 1", k, busy0); end
      checks++; if (i0 !== 4'b1001) begin errors++; $display("FAIL basic_I edge%0d got %b want 1001", k, i0); end
      tick();
    end
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL basic_done edge8 got %b want 1", done0); end
    checks++; if (cap0 !== 4'b1001) begin errors++; $display("FAIL basic_cap got %b want 1001", cap0); end
    checks++; if (mismatch0 !== 1'b0) begin errors++; $display("FAIL basic_mismatch got %b want 0", mismatch0); end
    checks++; if (s0 !== 2'b11) begin errors++; $display("FAIL basic_S_done got %b want 11", s0); end
    tick();
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy0); end
    checks++; if (cap0 !== 4'b1001) begin errors++; $display("FAIL basic_cap_hold got %b want 1001", cap0); end
  endtask

  task automatic test_y_tied();
    tie_zero = 1'b1;
    start0 = 1'b1; data_in0 = 4'b1001;
    tick();
    start0 = 1'b0;
    repeat (8) tick();
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL tied_done got %b want 1", done0); end
    checks++; if (cap0 !== 4'b0000) begin errors++; $display("FAIL tied_cap got %b want 0000", cap0); end
    checks++; if (mismatch0 !== 1'b1) begin errors++; $display("FAIL tied_mismatch got %b want 1", mismatch0); end
    repeat (2) tick();
    checks++; if (mismatch0 !== 1'b1) begin errors++; $display("FAIL tied_mismatch_hold got %b want 1", mismatch0); end
    checks++; if (cap0 !== 4'b0000) begin errors++; $display("FAIL tied_cap_hold got %b want 0000", cap0); end
    tie_zero = 1'b0;
  endtask

  task automatic test_start_ignored();
    int dc;
    dc = 0;
    start0 = 1'b1; data_in0 = 4'b1001;
    tick();
    for (int e = 1; e <= 12; e++) begin
      start0 = (e == 3) || (e == 5);
      if (e == 3) data_in0 = 4'b0110;
      tick();
      if (done0 === 1'b1) dc++;
      if (e <= 9) begin
        checks++; if (i0 !== 4'b1001) begin errors++; $display("FAIL ignore_I edge%0d got %b want 1001", e, i0); end
      end
      if (e == 8) begin
        checks++; if (cap0 !== 4'b1001) begin errors++; $display("FAIL ignore_cap got %b want 1001", cap0); end
      end
    end
    start0 = 1'b0;
    checks++; if (dc != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dc); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL ignore_idle got busy=%b want 0", busy0); end
  endtask

  task automatic test_reset_mid_scan();
    int dc;
    dc = 0;
    start0 = 1'b1; data_in0 = 4'b1001;
    tick();
    start0 = 1'b0;
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (i0 !== 4'b0)    begin errors++; $display("FAIL midrst_I got %b want 0000", i0); end
    checks++; if (s0 !== 2'b0)    begin errors++; $display("FAIL midrst_S got %b want 00", s0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done0); end
    checks++; if (cap0 !== 4'b0)  begin errors++; $display("FAIL midrst_cap got %b want 0000", cap0); end
    checks++; if (mismatch0 !== 1'b0) begin errors++; $display("FAIL midrst_mismatch got %b want 0", mismatch0); end
    repeat (3) begin
      tick();
      if (done0 === 1'b1) dc++;
    end
    @(negedge clk);
    rst = 1'b0;
    start0 = 1'b1; data_in0 = 4'b0110;
    tick();
    start0 = 1'b0;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL midrst_restart_busy got %b want 1", busy0); end
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e < 8 && done0 === 1'b1) dc++;
    end
    checks++; if (dc != 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", dc); end
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL midrst_done_after got %b want 1", done0); end
    checks++; if (cap0 !== 4'b0110) begin errors++; $display("FAIL midrst_cap_after got %b want 0110", cap0); end
    checks++; if (mismatch0 !== 1'b0) begin errors++; $display("FAIL midrst_mismatch_after got %b want 0", mismatch0); end
    tick();
  endtask

  task automatic test_back_to_back();
    int m;
    start0 = 1'b1; data_in0 = 4'b1111;
    tick();
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_busy edge0 got %b want 1", busy0); end
    for (int k = 1; k < 30; k++) begin
      tick();
      m = k % 10;
      checks++; if (busy0 !== (m != 9)) begin errors++; $display("FAIL b2b_busy edge%0d got %b want %b", k, busy0, (m != 9)); end
      if (m == 8) begin
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL b2b_done edge%0d got %b want 1", k, done0); end
        checks++; if (cap0 !== 4'b1111) begin errors++; $display("FAIL b2b_cap edge%0d got %b want 1111", k, cap0); end
      end
      if (m == 0) begin
        checks++; if (s0 !== 2'b00) begin errors++; $display("FAIL b2b_restart_S edge%0d got %b want 00", k, s0); end
      end
    end
    start0 = 1'b0;
    tick();
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_stop got busy=%b want 0", busy0); end
  endtask

  task automatic test_dwell1();
    logic [1:0] exp_s;
    start1 = 1'b1; data_in1 = 4'b0101;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_s = 2'(k);
      checks++; if (s1 !== exp_s) begin errors++; $display("FAIL dw1_S edge%0d got %b want %b", k, s1, exp_s); end
      checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL dw1_done_early edge%0d got %b want 0", k, done1); end
      tick();
    end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL dw1_done edge4 got %b want 1", done1); end
    checks++; if (cap1 !== 4'b0101) begin errors++; $display("FAIL dw1_cap got %b want 0101", cap1); end
    checks++; if (mismatch1 !== 1'b0) begin errors++; $display("FAIL dw1_mismatch got %b want 0", mismatch1); end
    tick();
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL dw1_busy_end got %b want 0", busy1); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_scan();
    test_y_tied();
    test_start_ignored();
    test_reset_mid_scan();
    test_back_to_back();
    test_dwell1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_controller.md
MUX_SCAN_CONTROLLER -- requirements
Module: mux_scan_controller

Interface
REQ-001 The block SHALL have parameter DWELL, default 2, giving the clock cycles each select value is held (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a scan of data_in; sampled only in IDLE.
REQ-005 The block SHALL have port data_in, input, 4 bits: word to be scanned.
REQ-006 The block SHALL have port I, output, 4 bits: registered data word driven to the downstream 4:1 mux inputs.
REQ-007 The block SHALL have port S, output, 2 bits: registered select driven to the downstream mux.
REQ-008 The block SHALL have port y_in, input, 1 bit: mux output Y returned to this block.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a scan is in progress (DRIVE or DONE).
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse at scan completion.
REQ-011 The block SHALL have port cap, output, 4 bits: word reassembled from sampled y_in.
REQ-012 The block SHALL have port mismatch, output, 1 bit: high when cap differs from I at completion.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, DRIVE and DONE, plus an internal dwell counter cnt (4 bits).
REQ-014 In IDLE with start=1 at an edge, the block SHALL latch data_in into I, set S=0, cnt=0, cap=0 and mismatch=0, and enter DRIVE.
REQ-015 In IDLE with start=0, the block SHALL hold all outputs unchanged (I, cap, mismatch keep the last scan's values).
REQ-016 In DRIVE, cnt SHALL increment each edge, and at the edge where cnt==DWELL-1 the block SHALL load cap[S] from y_in.
REQ-017 In that sampling edge with S<3, the block SHALL increment S, reset cnt to 0 and stay in DRIVE.
REQ-018 In that sampling edge with S==3, the block SHALL enter DONE, keep S=3, and set mismatch to (final cap including the new bit != I).
REQ-019 DONE SHALL last exactly one cycle, with done=1 only in DONE, followed by an unconditional return to IDLE.
REQ-020 Latency SHALL be: start sampled at edge 0, done high from edge 4*DWELL to edge 4*DWELL+1; each select value is held exactly DWELL cycles.
REQ-021 busy SHALL be 1 in DRIVE and DONE and 0 in IDLE.
REQ-022 start SHALL be ignored in DRIVE and DONE, with no queuing; the earliest restart is accepted in the IDLE cycle after DONE.
REQ-023 I SHALL be stable for the entire scan, and data_in changes during busy SHALL have no effect.
REQ-024 S SHALL follow the order 0,1,2,3 with no wrap to 0 within a scan; S returns to 0 only on the next accepted start or on reset.
REQ-025 cap and mismatch SHALL be valid while done=1 and SHALL be held until the next accepted start.

Reset
REQ-026 While rst=1, the block SHALL immediately, without waiting for clk, force state=IDLE, I=0, S=0, cnt=0, cap=0, busy=0, done=0 and mismatch=0.
REQ-027 Reset asserted mid-scan SHALL abort the scan with no done pulse, and a start after reset release SHALL begin a fresh scan.
REQ-028 The first edge after rst falls SHALL be able to accept start.

Verification (DWELL=2, ideal behavioural 4:1 mux Y=I[S] unless stated)
REQ-029 The bench SHALL apply start with data_in=1001 and require: S=00,00,01,01,10,10,11,11 over 8 cycles; done at edge 8 for 1 cycle; cap=1001; mismatch=0; busy low after edge 9.
REQ-030 The bench SHALL tie y_in to 0 and scan data_in=1001, requiring cap=0000 and mismatch=1 with done.
REQ-031 The bench SHALL pulse start and change data_in to 0110 at edges 3 and 5 of a 1001 scan, requiring I=1001 throughout, exactly one done, and cap=1001.
REQ-032 The bench SHALL assert rst asynchronously between edges 4 and 5 of a scan, requiring all outputs to be 0 before the next edge and no done; after release, a scan of 0110 SHALL yield cap=0110.
REQ-033 The bench SHALL hold start=1 continuously with data_in=1111, requiring scans to start at edges 0, 10, 20, ... (one IDLE cycle between them), each giving cap=1111.
REQ-034 The bench SHALL rerun with DWELL=1 and data_in=0101, requiring S to change every cycle, done at edge 4, and cap=0101.
